// File: rtl/dmem_map_pkg.sv
// dmem_map_pkg: address map, status bit positions and word type for dmem_responder
package dmem_map_pkg;
  typedef logic [31:0] word_t;
  localparam logic [9:0] ADDR_CYCLE      = 10'h200;
  localparam logic [9:0] ADDR_OUT_DATA   = 10'h201;
  localparam logic [9:0] ADDR_OUT_STATUS = 10'h202;
  localparam logic [9:0] ADDR_OUT_DROP   = 10'h203;
  localparam logic [9:0] ADDR_SCRATCH    = 10'h204;
  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_COUNT_LSB = 8;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: CPU DMEM strobes/address/data plus the valid/ready output stream
//   master: drives MemWrite, MemRead, address, write_data, out_ready
//   slave:  drives read_data, out_valid, out_data
interface dmem_responder_if #(parameter int ADDR_W = 10, parameter int DATA_W = 32);
  logic              MemWrite;
  logic              MemRead;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  modport master (output MemWrite, MemRead, address, write_data, out_ready,
                  input read_data, out_valid, out_data);
  modport slave (input MemWrite, MemRead, address, write_data, out_ready,
                 output read_data, out_valid, out_data);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: registered FIFO; push accepted when not full or when popping in the same cycle
//   clk/rst: clock, sync active-high reset; push/pop: requests; din/dout: data (dout 0 when empty)
//   empty/full/count: occupancy flags and count
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign empty = count == '0;
  assign full  = count == (AW+1)'(DEPTH);
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;
  // Gate the head so an empty FIFO presents 0 without clearing storage
  assign dout  = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(wr);
      rp    <= rp + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (!rst && wr) mem[wp] <= din;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: DMEM responder with word RAM and MMIO bank (cycle, scratch, output FIFO)
//   CLK/RST: clock, sync active-high reset
//   bus (slave): MemWrite/MemRead/address/write_data in, read_data out (combinational),
//                out_valid/out_data/out_ready stream of pushed words
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RAM_DEPTH  = 512,
  parameter int FIFO_DEPTH = 8
) (
  input logic CLK,
  input logic RST,
  dmem_responder_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [DATA_W-1:0] ram [RAM_DEPTH];
  word_t cycle, scratch, drop, status;
  logic empty, full, pop, push_req, is_ram;
  logic [CW-1:0] count;
  assign is_ram        = !bus.address[ADDR_W-1];
  assign push_req      = bus.MemWrite && bus.address == ADDR_OUT_DATA;
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_valid = !empty;
  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk(CLK), .rst(RST), .push(push_req), .pop(pop), .din(bus.write_data),
    .dout(bus.out_data), .empty(empty), .full(full), .count(count)
  );
  always_comb begin
    status = '0;
    status[STATUS_EMPTY_BIT] = empty;
    status[STATUS_FULL_BIT] = full;
    status[STATUS_COUNT_LSB +: CW] = count;
  end
  always_comb
    bus.read_data = !bus.MemRead                   ? '0 :
                    is_ram                         ? ram[bus.address[ADDR_W-2:0]] :
                    bus.address == ADDR_CYCLE      ? cycle :
                    bus.address == ADDR_OUT_STATUS ? status :
                    bus.address == ADDR_OUT_DROP   ? drop :
                    bus.address == ADDR_SCRATCH    ? scratch : '0;
  always_ff @(posedge CLK)
    if (RST) begin
      cycle   <= '0;
      scratch <= '0;
      drop    <= '0;
    end else begin
      cycle <= cycle + 1;
      if (bus.MemWrite && bus.address == ADDR_SCRATCH) scratch <= bus.write_data;
      // A full-FIFO push is only lost when no pop frees a slot in the same cycle
      if (push_req && full && !pop && drop != '1) drop <= drop + 1;
    end
  always_ff @(posedge CLK)
    if (!RST && bus.MemWrite && is_ram) ram[bus.address[ADDR_W-2:0]] <= bus.write_data;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (read and stream queues checked by a monitor)
module tb_dmem_responder;
  import dmem_map_pkg::*;
  typedef struct { string nm; word_t v; } exp_t;
  logic clk = 0, rst = 1;
  int checks = 0, errors = 0;
  logic rd_chk = 0;
  exp_t rd_q[$];
  exp_t st_q[$];
  dmem_responder_if #(.ADDR_W(10), .DATA_W(32)) bus();
  dmem_responder dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    exp_t e;
    if (rd_chk) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_queue_empty read_data=%h", bus.read_data);
      end else begin
        e = rd_q.pop_front();
        if (bus.read_data !== e.v) begin
          errors++;
          $display("FAIL %s got %h want %h", e.nm, bus.read_data, e.v);
        end
      end
    end
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (st_q.size() == 0) begin
        errors++;
        $display("FAIL stream_unexpected out_data=%h", bus.out_data);
      end else begin
        e = st_q.pop_front();
        if (bus.out_data !== e.v) begin
          errors++;
          $display("FAIL %s got %h want %h", e.nm, bus.out_data, e.v);
        end
      end
    end
  end
  task automatic chk(input string nm, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic op(input logic w, input logic r, input logic [9:0] a, input word_t d,
                    input logic rdy, input logic c, input word_t e, input string nm);
    bus.MemWrite = w;
    bus.MemRead = r;
    bus.address = a;
    bus.write_data = d;
    bus.out_ready = rdy;
    rd_chk = c;
    if (c) rd_q.push_back('{nm, e});
    @(posedge clk);
    #1;
    bus.MemWrite = 0;
    bus.MemRead = 0;
    rd_chk = 0;
  endtask
  task automatic rd(input logic [9:0] a, input word_t e, input string nm);
    op(0, 1, a, 0, 0, 1, e, nm);
  endtask
  task automatic wr(input logic [9:0] a, input word_t d);
    op(1, 0, a, d, 0, 0, 0, "");
  endtask
  task automatic idle(input logic rdy);
    op(0, 0, 0, 0, rdy, 0, 0, "");
  endtask
  task automatic psh(input word_t d, input logic rdy, input logic acc);
    if (acc) st_q.push_back('{$sformatf("stream_%0h", d), d});
    op(1, 0, ADDR_OUT_DATA, d, rdy, 0, 0, "");
  endtask
  initial begin
    int fib[8] = '{0, 1, 1, 2, 3, 5, 8, 13};
    bus.MemWrite = 0;
    bus.MemRead = 0;
    bus.address = 0;
    bus.write_data = 0;
    bus.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", word_t'(bus.out_valid), 0);
    chk("reset_out_data", bus.out_data, 0);
    rd(ADDR_OUT_STATUS, 32'h1, "reset_status");
    rd(ADDR_OUT_DROP, 0, "reset_drop");
    rd(ADDR_SCRATCH, 0, "reset_scratch");
    rd(ADDR_CYCLE, 0, "reset_cycle");
    rst = 0;
    repeat (10) idle(0);
    rd(ADDR_CYCLE, 10, "cycle_10");
    dut.cycle = 32'hFFFF_FFFF;
    rd(ADDR_CYCLE, 32'hFFFF_FFFF, "cycle_max");
    rd(ADDR_CYCLE, 0, "cycle_wrap");
    wr(10'h005, 32'hDEADBEEF);
    wr(10'h1FF, 32'h12345678);
    rd(10'h005, 32'hDEADBEEF, "ram_005");
    rd(10'h1FF, 32'h12345678, "ram_1ff");
    op(0, 0, 10'h005, 0, 0, 1, 0, "ram_noread_zero");
    for (int i = 0; i < 8; i++) psh(fib[i], 0, 1);
    rd(ADDR_OUT_STATUS, 32'h802, "fib_status_full");
    repeat (8) idle(1);
    chk("fib_drained", st_q.size(), 0);
    chk("fib_valid_low", word_t'(bus.out_valid), 0);
    op(0, 1, ADDR_OUT_STATUS, 0, 1, 1, 32'h1, "fib_status_empty");
    for (int i = 0; i < 8; i++) psh(32'h10 + i, 0, 1);
    psh(32'h99, 0, 0);
    rd(ADDR_OUT_DROP, 1, "ovf_drop_1");
    rd(ADDR_OUT_STATUS, 32'h802, "ovf_status_full");
    psh(32'hAA, 1, 1);
    rd(ADDR_OUT_STATUS, 32'h802, "ovf_status_after_pushpop");
    rd(ADDR_OUT_DROP, 1, "ovf_drop_still_1");
    repeat (8) idle(1);
    chk("ovf_drained", st_q.size(), 0);
    op(1, 1, ADDR_SCRATCH, 32'h55, 0, 1, 0, "scratch_rw_old");
    rd(ADDR_SCRATCH, 32'h55, "scratch_new");
    wr(10'h3FF, 32'h1234);
    rd(10'h3FF, 0, "unmapped_3ff");
    wr(ADDR_CYCLE, 32'h0);
    wr(ADDR_OUT_STATUS, 32'hFFFF);
    rd(ADDR_OUT_STATUS, 32'h1, "ro_status_ignored");
    for (int i = 0; i < 5; i++) psh(32'h30 + i, 0, 1);
    dut.cycle = 32'd39;
    idle(0);
    rd(ADDR_CYCLE, 40, "pre_reset_cycle");
    rd(ADDR_OUT_STATUS, 32'h500, "pre_reset_status");
    rst = 1;
    op(1, 0, ADDR_OUT_DATA, 32'h77, 1, 0, 0, "");
    rst = 0;
    st_q.delete();
    chk("post_reset_valid", word_t'(bus.out_valid), 0);
    rd(ADDR_CYCLE, 0, "post_reset_cycle");
    rd(ADDR_OUT_STATUS, 32'h1, "post_reset_status");
    rd(ADDR_OUT_DROP, 0, "post_reset_drop");
    rd(ADDR_SCRATCH, 0, "post_reset_scratch");
    rd(10'h005, 32'hDEADBEEF, "post_reset_ram_005");
    rd(10'h1FF, 32'h12345678, "post_reset_ram_1ff");
    idle(1);
    chk("post_reset_out_data", bus.out_data, 0);
    chk("rd_queue_drained", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
